// File: rtl/ro_scan_controller.sv
// Ring-oscillator scan sequencer: selects each oscillator/tap, settles, gates a rising-edge count of the mux output.
// Optional scan skip mask enabled by defining RO_SCAN_SKIP_MASK_EN.
module ro_scan_controller #(
   parameter int NUM_RO        = 16,
   parameter int NUM_TAP       = 5,
   parameter int SETTLE_CYCLES = 16,
   parameter int GATE_CYCLES   = 1024,
   parameter int CNT_W         = 16,
   parameter int RO_W          = $clog2(NUM_RO)
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               scan_start_i,
   input  logic               single_i,
   input  logic [RO_W-1:0]    cfg_ro_i,
   input  logic [2:0]         cfg_tap_i,
`ifdef RO_SCAN_SKIP_MASK_EN
   input  logic [NUM_RO-1:0]  ro_mask_i,
`endif
   input  logic               ro_in,
   output logic [RO_W-1:0]    ro_sel_o,
   output logic [NUM_TAP-1:0] tap_o,
   output logic               ro_start_o,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [RO_W-1:0]    res_ro_o,
   output logic [2:0]         res_tap_o,
   output logic [CNT_W-1:0]   res_count_o,
   output logic               busy_o,
   output logic               done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SETTLE, S_GATE, S_REPORT, S_NEXT, S_DONE
   } state_t;

   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [2:0]      TAP_LAST = 3'(NUM_TAP - 1);
   localparam logic [RO_W-1:0] RO_LAST  = RO_W'(NUM_RO - 1);

   state_t            state, state_d;
   logic [RO_W-1:0]   ro_q, ro_d;
   logic [2:0]        tap_q, tap_d;
   logic              single_q, single_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ro_sync1, ro_sync2, ro_prev, ro_rise;
   logic [NUM_RO-1:0] skip_mask;
   logic              first_found, after_found;
   logic [RO_W-1:0]   first_ro, after_ro;
   logic [2:0]        cfg_tap_clamped;

`ifdef RO_SCAN_SKIP_MASK_EN
   assign skip_mask = ro_mask_i;
`else
   assign skip_mask = '0;
`endif

   assign ro_rise         = ro_sync2 & ~ro_prev;
   assign cfg_tap_clamped = (int'(cfg_tap_i) >= NUM_TAP) ? TAP_LAST : cfg_tap_i;

   // Lowest unmasked oscillator overall, and lowest unmasked one above the current index.
   always_comb begin
      first_found = 1'b0;
      first_ro    = '0;
      after_found = 1'b0;
      after_ro    = '0;
      for (int i = NUM_RO - 1; i >= 0; i--) begin
         if (!skip_mask[i]) begin
            first_found = 1'b1;
            first_ro    = RO_W'(i);
            if (i > int'(ro_q)) begin
               after_found = 1'b1;
               after_ro    = RO_W'(i);
            end
         end
      end
   end

   always_comb begin
      state_d     = state;
      ro_d        = ro_q;
      tap_d       = tap_q;
      single_d    = single_q;
      tmr_d       = tmr_q;
      cnt_d       = cnt_q;
      busy_o      = (state != S_IDLE);
      ro_start_o  = 1'b0;
      res_valid_o = 1'b0;
      done_o      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (scan_start_i) begin
               single_d = single_i;
               state_d  = S_SETUP;
               if (single_i) begin
                  ro_d  = cfg_ro_i;
                  tap_d = cfg_tap_clamped;
               end else if (first_found) begin
                  ro_d  = first_ro;
                  tap_d = '0;
               end else begin
                  // Nothing to scan: park on the last index so NEXT finishes the run.
                  ro_d    = RO_LAST;
                  tap_d   = TAP_LAST;
                  state_d = S_NEXT;
               end
            end
         end
         S_SETUP: begin
            tmr_d   = '0;
            cnt_d   = '0;
            state_d = (SETTLE_CYCLES == 0) ? S_GATE : S_SETTLE;
         end
         S_SETTLE: begin
            ro_start_o = 1'b1;
            if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
               tmr_d   = '0;
               state_d = S_GATE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_GATE: begin
            ro_start_o = 1'b1;
            if (ro_rise && (cnt_q != '1))
               cnt_d = cnt_q + 1'b1;
            if (tmr_q == TMR_W'(GATE_CYCLES - 1))
               state_d = S_REPORT;
            else
               tmr_d = tmr_q + 1'b1;
         end
         S_REPORT: begin
            res_valid_o = 1'b1;
            if (res_ready_i)
               state_d = S_NEXT;
         end
         S_NEXT: begin
            if (single_q) begin
               state_d = S_DONE;
            end else if (tap_q < TAP_LAST) begin
               tap_d   = tap_q + 1'b1;
               state_d = S_SETUP;
            end else if (after_found) begin
               ro_d    = after_ro;
               tap_d   = '0;
               state_d = S_SETUP;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= S_IDLE;
         ro_q     <= '0;
         tap_q    <= '0;
         single_q <= 1'b0;
         tmr_q    <= '0;
         cnt_q    <= '0;
         ro_sync1 <= 1'b0;
         ro_sync2 <= 1'b0;
         ro_prev  <= 1'b0;
      end else begin
         state    <= state_d;
         ro_q     <= ro_d;
         tap_q    <= tap_d;
         single_q <= single_d;
         tmr_q    <= tmr_d;
         cnt_q    <= cnt_d;
         ro_sync1 <= ro_in;
         ro_sync2 <= ro_sync1;
         ro_prev  <= ro_sync2;
      end
   end

   assign ro_sel_o    = ro_q;
   assign tap_o       = NUM_TAP'(1) << tap_q;
   assign res_ro_o    = ro_q;
   assign res_tap_o   = tap_q;
   assign res_count_o = cnt_q;

endmodule

// File: tb/tb_ro_scan_controller.sv
// Directed bench for ro_scan_controller: reset, single runs, saturation, mid-gate reset, full scan under backpressure.
module tb_ro_scan_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scan_start = 1'b0;
   logic        single = 1'b0;
   logic [3:0]  cfg_ro = '0;
   logic [2:0]  cfg_tap = '0;
   logic        ro_in = 1'b0;
   logic        res_ready = 1'b0;
`ifdef RO_SCAN_SKIP_MASK_EN
   logic [15:0] ro_mask = '0;
`endif

   logic [3:0]  ro_sel, res_ro, s_ro_sel, s_res_ro;
   logic [4:0]  tap, s_tap;
   logic [2:0]  res_tap, s_res_tap;
   logic        ro_start, res_valid, busy, done;
   logic        s_ro_start, s_res_valid, s_busy, s_done;
   logic [15:0] res_count;
   logic [3:0]  s_res_count;

   int n_chk = 0, n_pass = 0;
   int ro_half = 0;
   int done_cnt = 0, hs_cnt = 0, rep_viol = 0, hs_bad_ro = 0;
   int exp_hs_ro = 0;
   bit hs_ro_chk = 1'b0;

   ro_scan_controller #(.SETTLE_CYCLES(16), .GATE_CYCLES(64), .CNT_W(16)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .scan_start_i(scan_start), .single_i(single),
      .cfg_ro_i(cfg_ro), .cfg_tap_i(cfg_tap),
`ifdef RO_SCAN_SKIP_MASK_EN
      .ro_mask_i(ro_mask),
`endif
      .ro_in(ro_in), .ro_sel_o(ro_sel), .tap_o(tap), .ro_start_o(ro_start),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_ro_o(res_ro),
      .res_tap_o(res_tap), .res_count_o(res_count), .busy_o(busy), .done_o(done));

   ro_scan_controller #(.SETTLE_CYCLES(16), .GATE_CYCLES(64), .CNT_W(4)) dut_sat (
      .wb_clk_i(clk), .wb_rst_i(rst), .scan_start_i(scan_start), .single_i(single),
      .cfg_ro_i(cfg_ro), .cfg_tap_i(cfg_tap),
`ifdef RO_SCAN_SKIP_MASK_EN
      .ro_mask_i(ro_mask),
`endif
      .ro_in(ro_in), .ro_sel_o(s_ro_sel), .tap_o(s_tap), .ro_start_o(s_ro_start),
      .res_valid_o(s_res_valid), .res_ready_i(res_ready), .res_ro_o(s_res_ro),
      .res_tap_o(s_res_tap), .res_count_o(s_res_count), .busy_o(s_busy), .done_o(s_done));

   always #5 clk = ~clk;

   // ro_in toggles every ro_half clocks (0 = hold)
   initial begin
      int ctr;
      ctr = 0;
      forever begin
         @(negedge clk);
         if (ro_half != 0) begin
            ctr++;
            if (ctr >= ro_half) begin
               ctr   = 0;
               ro_in = ~ro_in;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (done === 1'b1) done_cnt++;
         if (res_valid === 1'b1 && ro_start !== 1'b0) rep_viol++;
         if (res_valid === 1'b1 && res_ready === 1'b1) begin
            hs_cnt++;
            if (hs_ro_chk && res_ro !== 4'(exp_hs_ro)) hs_bad_ro++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // Pulse scan_start; returns at the negedge after the sampling edge.
   task automatic start_run(input logic s, input logic [3:0] r, input logic [2:0] t);
      single = s; cfg_ro = r; cfg_tap = t; scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
   endtask

   task automatic wait_valid(inout int lat);
      while (res_valid !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, d0, h0, ord_err, stab_err, cnt_err, nres, v;
      logic [3:0]  c_ro;
      logic [2:0]  c_tap;
      logic [15:0] c_cnt;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_start", ro_start, 0);
      chk("rst_sel", ro_sel, 0);
      chk("rst_tap", tap, 5'b00001);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // single measurement, ro_in period 8 clocks -> 8 edges in 64
      ro_half = 4; res_ready = 1'b1;
      repeat (4) @(negedge clk);
      d0 = done_cnt; h0 = hs_cnt;
      start_run(1'b1, 4'd7, 3'd2);
      chk("setup_sel", ro_sel, 7);
      chk("setup_tap", tap, 5'b00100);
      chk("setup_start", ro_start, 0);
      @(negedge clk);
      chk("settle_start", ro_start, 1);
      lat = 1;
      wait_valid(lat);
      chk("latency", lat, 81);
      chk("res_ro", res_ro, 7);
      chk("res_tap", res_tap, 2);
      chk("res_count", res_count, 8);
      chk("sat_unsat_count", s_res_count, 8);
      chk("report_start", ro_start, 0);
      @(negedge clk);
      chk("valid_drop", res_valid, 0);
      repeat (4) @(negedge clk);
      chk("single_done", done_cnt - d0, 1);
      chk("single_hs", hs_cnt - h0, 1);
      chk("single_idle", busy, 0);

      // saturation: period 4 -> 16 edges; 4-bit counter holds at 15
      ro_half = 2;
      repeat (4) @(negedge clk);
      start_run(1'b1, 4'd0, 3'd7);
      chk("clamp_tap", tap, 5'b10000);
      lat = 0;
      wait_valid(lat);
      chk("sat_main", res_count, 16);
      chk("sat_4b", s_res_count, 15);
      chk("sat_valid", s_res_valid, 1);
      repeat (5) @(negedge clk);

      // reset in gate cycle 30
      ro_half = 4;
      start_run(1'b1, 4'd3, 3'd1);
      repeat (46) @(negedge clk);
      chk("gate30_start", ro_start, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_start", ro_start, 0);
      chk("midrst_valid", res_valid, 0);
      rst = 1'b0;
      v = 0;
      repeat (100) begin
         @(negedge clk);
         if (res_valid) v++;
      end
      chk("midrst_no_valid", v, 0);
      d0 = done_cnt; h0 = hs_cnt;
      start_run(1'b1, 4'd3, 3'd1);
      repeat (5) @(negedge clk);
      start_run(1'b0, 4'd9, 3'd4);
      lat = 0;
      wait_valid(lat);
      chk("fresh_count", res_count, 8);
      chk("fresh_ro", res_ro, 3);
      chk("fresh_tap", res_tap, 1);
      repeat (5) @(negedge clk);
      chk("busy_ignore_hs", hs_cnt - h0, 1);
      chk("busy_ignore_done", done_cnt - d0, 1);

      // full scan with 10-cycle backpressure per result; period 6 -> 10 or 11 edges
      ro_half = 3; res_ready = 1'b0;
      ord_err = 0; stab_err = 0; cnt_err = 0; nres = 0;
      d0 = done_cnt;
      start_run(1'b0, 4'd0, 3'd0);
      for (int r = 0; r < 80; r++) begin
         lat = 0;
         wait_valid(lat);
         if (lat >= 400) begin
            chk("scan_timeout", r, 80);
            break;
         end
         c_ro = res_ro; c_tap = res_tap; c_cnt = res_count;
         if (int'(c_ro) != r / 5 || int'(c_tap) != r % 5) ord_err++;
         if (c_cnt != 16'd10 && c_cnt != 16'd11) cnt_err++;
         repeat (10) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_ro !== c_ro || res_tap !== c_tap || res_count !== c_cnt)
               stab_err++;
         end
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         nres++;
      end
      repeat (5) @(negedge clk);
      chk("scan_results", nres, 80);
      chk("scan_order", ord_err, 0);
      chk("scan_stable", stab_err, 0);
      chk("scan_counts", cnt_err, 0);
      chk("scan_done", done_cnt - d0, 1);
      chk("scan_idle", busy, 0);
      chk("report_no_start", rep_viol, 0);

`ifdef RO_SCAN_SKIP_MASK_EN
      res_ready = 1'b1; hs_ro_chk = 1'b1;
      exp_hs_ro = 0; ro_mask = 16'hFFFE;
      d0 = done_cnt; h0 = hs_cnt; hs_bad_ro = 0;
      start_run(1'b0, 4'd5, 3'd3);
      v = 0;
      while (done_cnt == d0 && v < 2000) begin @(negedge clk); v++; end
      chk("mask0_results", hs_cnt - h0, 5);
      chk("mask0_ro", hs_bad_ro, 0);
      repeat (3) @(negedge clk);
      exp_hs_ro = 14; ro_mask = 16'hBFFF;
      d0 = done_cnt; h0 = hs_cnt;
      start_run(1'b0, 4'd0, 3'd0);
      v = 0;
      while (done_cnt == d0 && v < 2000) begin @(negedge clk); v++; end
      chk("mask14_results", hs_cnt - h0, 5);
      chk("mask14_ro", hs_bad_ro, 0);
      repeat (3) @(negedge clk);
      ro_mask = 16'hFFFF;
      h0 = hs_cnt;
      start_run(1'b0, 4'd0, 3'd0);
      chk("allmask_done_t1", done, 0);
      @(negedge clk);
      chk("allmask_done_t2", done, 1);
      repeat (3) @(negedge clk);
      chk("allmask_results", hs_cnt - h0, 0);
      chk("allmask_idle", busy, 0);
      ro_mask = '0; hs_ro_chk = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
